// File: rtl/artec_dma_pkg.sv
// Shared AXI encodings, 4 KB page constants and the read-FSM state type
// for the DMA read path.
package artec_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B    = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         PAGE_BYTES      = 4096;
  localparam int         BEAT_BYTES      = 16;
  localparam logic [1:0] MAX_OUTSTANDING = 2'd2;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/artec_r2axis_gearbox.sv
// 128->64 downsizer: one AXI R beat becomes two AXI-Stream beats, low half first.
// tlast is placed on the upper half of the beat flagged as the descriptor's last.
module artec_r2axis_gearbox #(
  parameter int SDW = 64,
  parameter int UW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rvalid,
  output logic               rready,
  input  logic [2*SDW-1:0]   rdata,
  input  logic               r_final,
  input  logic [UW-1:0]      user,
  output logic               tvalid,
  input  logic               tready,
  output logic [SDW-1:0]     tdata,
  output logic [SDW/8-1:0]   tkeep,
  output logic               tlast,
  output logic [UW-1:0]      tuser,
  output logic               empty
);

  logic [SDW-1:0] hi_p0;
  logic           vld_p0;
  logic           last_p0;
  logic [SDW-1:0] out_p1;
  logic           vld_p1;
  logic           last_p1;
  logic [UW-1:0]  user_p1;
  logic           r_fire;
  logic           t_fire;

  // A new R beat fits when the output is free, or only the upper half is
  // left and it leaves this cycle; this sustains one AXIS beat per cycle.
  assign rready = !vld_p1 || (!vld_p0 && tready);
  assign r_fire = rvalid && rready;
  assign t_fire = vld_p1 && tready;

  // stage p0: pending upper half; stage p1: AXIS output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_p0   <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      out_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      user_p1 <= '0;
    end else if (r_fire) begin
      out_p1  <= rdata[SDW-1:0];
      vld_p1  <= 1'b1;
      last_p1 <= 1'b0;
      user_p1 <= user;
      hi_p0   <= rdata[2*SDW-1:SDW];
      vld_p0  <= 1'b1;
      last_p0 <= r_final;
    end else if (t_fire) begin
      if (vld_p0) begin
        out_p1  <= hi_p0;
        last_p1 <= last_p0;
        vld_p0  <= 1'b0;
      end else begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign tvalid = vld_p1;
  assign tdata  = out_p1;
  assign tkeep  = '1;
  assign tlast  = last_p1;
  assign tuser  = user_p1;
  assign empty  = !vld_p1;

endmodule

// File: rtl/artec_axi_to_axis_rd.sv
// DMA read path: one descriptor at a time is split into 4 KB-safe AXI4 INCR
// bursts (at most two in flight) and replayed as a 64-bit AXI-Stream.
module artec_axi_to_axis_rd
  import artec_dma_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 128,
  parameter int SDW  = 64,
  parameter int UW   = 5,
  parameter int IDW  = 4,
  parameter int MAXB = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [AW-1:0]      desc_addr,
  input  logic [15:0]        desc_len,
  input  logic [UW-1:0]      desc_user,
  output logic               arvalid,
  input  logic               arready,
  output logic [AW-1:0]      araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic [IDW-1:0]     arid,
  input  logic               rvalid,
  output logic               rready,
  input  logic [DW-1:0]      rdata,
  input  logic [1:0]        rresp,
  input  logic               rlast,
  input  logic [IDW-1:0]     rid,
  output logic               tvalid,
  input  logic               tready,
  output logic [SDW-1:0]     tdata,
  output logic [SDW/8-1:0]   tkeep,
  output logic               tlast,
  output logic [UW-1:0]      tuser,
  output logic               done,
  output logic               err
);

  rd_state_t     state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [16:0]   remaining_q;
  logic [16:0]   rx_left_q;
  logic [16:0]   beats;
  logic [8:0]    page_left;
  logic [UW-1:0] user_q;
  logic          err_acc_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    outstanding_q;
  logic          accept, ar_fire, r_fire, t_fire, busy;
  logic          gb_rvalid, gb_rready, gb_empty;
  logic          unused_ok;

  // Single ID, in-order responses: rid carries no information here.
  assign unused_ok = ^{rid, desc_addr[3:0], gb_empty};

  assign busy       = (state_q != RD_IDLE);
  assign desc_ready = (state_q == RD_IDLE) && !rst;
  assign accept     = desc_valid && desc_ready;
  assign page_left  = 9'(PAGE_BYTES / BEAT_BYTES) - {1'b0, addr_q[11:4]};

  always_comb begin
    beats = remaining_q;
    if (beats > 17'(MAXB))        beats = 17'(MAXB);
    if (beats > {8'd0, page_left}) beats = {8'd0, page_left};
  end

  assign arvalid = (state_q == RD_ADDR) && (outstanding_q < MAX_OUTSTANDING);
  assign araddr  = addr_q;
  assign arlen   = arvalid ? 8'(beats - 17'd1) : 8'd0;
  assign arsize  = AXI_SIZE_16B;
  assign arburst = AXI_BURST_INCR;
  assign arid    = '0;
  assign ar_fire = arvalid && arready;

  assign gb_rvalid = rvalid && busy;
  assign rready    = gb_rready && busy;
  assign r_fire    = rvalid && rready;
  assign t_fire    = tvalid && tready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:  if (accept) state_d = RD_ADDR;
      RD_ADDR:  if (ar_fire && (remaining_q == beats)) state_d = RD_DRAIN;
      // The final tlast can only leave once every burst has returned.
      RD_DRAIN: if (t_fire && tlast) state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      rx_left_q     <= '0;
      user_q        <= '0;
      err_acc_q     <= 1'b0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= {desc_addr[AW-1:4], 4'h0};
        remaining_q <= {1'b0, desc_len} + 17'd1;
        rx_left_q   <= {1'b0, desc_len} + 17'd1;
        user_q      <= desc_user;
        err_acc_q   <= 1'b0;
      end else begin
        if (ar_fire) begin
          addr_q      <= addr_q + AW'({beats, 4'h0});
          remaining_q <= remaining_q - beats;
        end
        if (r_fire) begin
          rx_left_q <= rx_left_q - 17'd1;
          if (rresp != AXI_RESP_OKAY) err_acc_q <= 1'b1;
        end
      end
      unique case ({ar_fire, r_fire && rlast})
        2'b10:   outstanding_q <= outstanding_q + 2'd1;
        2'b01:   outstanding_q <= outstanding_q - 2'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      done_q <= t_fire && tlast;
      err_q  <= t_fire && tlast && err_acc_q;
    end
  end

  assign done = done_q;
  assign err  = err_q;

  artec_r2axis_gearbox #(
    .SDW (SDW),
    .UW  (UW)
  ) u_gearbox (
    .clk     (clk),
    .rst     (rst),
    .rvalid  (gb_rvalid),
    .rready  (gb_rready),
    .rdata   (rdata),
    .r_final (rx_left_q == 17'd1),
    .user    (user_q),
    .tvalid  (tvalid),
    .tready  (tready),
    .tdata   (tdata),
    .tkeep   (tkeep),
    .tlast   (tlast),
    .tuser   (tuser),
    .empty   (gb_empty)
  );

endmodule

// File: tb/tb_artec_axi_to_axis_rd.sv
// Bench for artec_axi_to_axis_rd: AXI read slave with a synthetic memory,
// randomized handshakes, and an AXIS sink compared against a reference model.
module tb_artec_axi_to_axis_rd;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         desc_valid;
  logic         desc_ready;
  logic [31:0]  desc_addr;
  logic [15:0]  desc_len;
  logic [4:0]   desc_user;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid, rready;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [3:0]   rid;
  logic         tvalid, tready;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast;
  logic [4:0]   tuser;
  logic         done, err;

  always #5 clk = ~clk;

  artec_axi_to_axis_rd dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_user(desc_user),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep),
    .tlast(tlast), .tuser(tuser), .done(done), .err(err)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [63:0] d; logic l; logic [4:0] u;} ax_t;

  int total = 0;
  int bad   = 0;

  // memory image: every 16-byte word is a function of its address
  logic [31:0] q_addr[$];
  int          q_left[$];
  ar_t         ar_log[$];
  ax_t         got[$];
  int          tready_pct = 100, arready_pct = 100, rvalid_pct = 100;
  int          err_beat = -1, r_idx = 0;
  int          outst = 0, max_outst = 0, ar_attr_bad = 0, keep_bad = 0;
  int          cyc = 0, tlast_cyc = -2, done_cyc = -1;
  logic        done_err, done_rdy;
  bit          ar_f, r_f, t_f;

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'd7, ~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ar_addr_at(input int i);
    return (ar_log.size() > i) ? ar_log[i].addr : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] ar_len_at(input int i);
    return (ar_log.size() > i) ? ar_log[i].len : 8'hFF;
  endfunction

  // AXI slave + AXIS sink: observe at negedge, drive just after posedge
  always begin
    @(negedge clk);
    cyc++;
    ar_f = 1'b0; r_f = 1'b0; t_f = 1'b0;
    if (rst) begin
      q_addr.delete(); q_left.delete(); outst = 0;
    end else begin
      if (done) begin done_cyc = cyc; done_err = err; done_rdy = desc_ready; end
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      t_f  = tvalid && tready;
      if (ar_f) begin
        q_addr.push_back(araddr);
        q_left.push_back(int'(arlen) + 1);
        ar_log.push_back('{addr: araddr, len: arlen});
        outst++;
        if (outst > max_outst) max_outst = outst;
        if (arsize !== 3'b100 || arburst !== 2'b01 || arid !== 4'd0) ar_attr_bad++;
      end
      if (r_f) begin
        r_idx++;
        if (rlast) outst--;
        q_left[0]--;
        q_addr[0] += 32'd16;
        if (q_left[0] == 0) begin q_addr.pop_front(); q_left.pop_front(); end
      end
      if (t_f) begin
        got.push_back('{d: tdata, l: tlast, u: tuser});
        if (tkeep !== 8'hFF) keep_bad++;
        if (tlast) tlast_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      arready = 1'b0; tready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    end else begin
      arready = ($urandom_range(0, 99) < arready_pct);
      tready  = ($urandom_range(0, 99) < tready_pct);
      if (!(rvalid && !r_f)) begin
        if (q_addr.size() > 0 && $urandom_range(0, 99) < rvalid_pct) begin
          rvalid = 1'b1;
          rdata  = mem_word(q_addr[0]);
          rlast  = (q_left[0] == 1);
          rresp  = (r_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end
  end

  task automatic send_desc(input logic [31:0] a, input int len, input logic [4:0] u,
                           input string tag);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    desc_valid = 1'b1; desc_addr = a; desc_len = 16'(len); desc_user = u;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (desc_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    chk({tag, "_accepted"}, ok, 1'b1);
    chk({tag, "_arvalid_next"}, arvalid, 1'b1);
  endtask

  task automatic run_desc(input logic [31:0] a, input int len, input logic [4:0] u,
                          input int eb, input logic exp_err, input string tag);
    ar_t         exp_ar[$];
    logic [31:0] base = {a[31:4], 4'h0};
    logic [31:0] a2   = {a[31:4], 4'h0};
    int          rem  = len + 1;
    int          n    = 2 * (len + 1);
    int          nb   = 0;
    int          b, pg;
    logic [127:0] w;
    logic [63:0]  ed;
    ar_log.delete(); got.delete();
    err_beat = eb; r_idx = 0; max_outst = 0; ar_attr_bad = 0; keep_bad = 0;
    done_cyc = -1; tlast_cyc = -2;
    send_desc(a, len, u, tag);
    for (int k = 0; k < 6000 && done_cyc < 0; k++) @(negedge clk);
    chk({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
    chk({tag, "_done_after_tlast"}, done_cyc, tlast_cyc + 1);
    chk({tag, "_ready_with_done"}, done_rdy, 1'b1);
    chk({tag, "_err"}, done_err, exp_err);
    // expected burst list from the 4 KB / MAXB rules
    while (rem > 0) begin
      pg = (4096 - int'(a2 % 4096)) / 16;
      b  = rem;
      if (b > 16) b = 16;
      if (b > pg) b = pg;
      exp_ar.push_back('{addr: a2, len: 8'(b - 1)});
      a2  += 32'(b * 16);
      rem -= b;
    end
    chk({tag, "_ar_count"}, ar_log.size(), exp_ar.size());
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      if (ar_log[i] !== exp_ar[i]) nb++;
    chk({tag, "_ar_list"}, nb, 0);
    chk({tag, "_ar_attrs"}, ar_attr_bad, 0);
    chk({tag, "_max_outst_le2"}, max_outst <= 2, 1'b1);
    nb = 0;
    for (int i = 0; i < got.size() && i < n; i++) begin
      w  = mem_word(base + 32'(16 * (i / 2)));
      ed = (i % 2 == 1) ? w[127:64] : w[63:0];
      if (got[i].d !== ed || got[i].l !== (i == n - 1) || got[i].u !== u) nb++;
    end
    chk({tag, "_beat_count"}, got.size(), n);
    chk({tag, "_beat_data"}, nb, 0);
    chk({tag, "_tkeep"}, keep_bad, 0);
  endtask

  task automatic chk_reset_outputs(input string tag, input logic exp_ready);
    chk({tag, "_desc_ready"}, desc_ready, exp_ready);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_tvalid"}, tvalid, 1'b0);
    chk({tag, "_tlast"}, tlast, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_arlen"}, arlen, 8'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_tuser"}, tuser, 5'd0);
  endtask

  initial begin
    logic [31:0] ra;
    desc_valid = 1'b0; desc_addr = '0; desc_len = '0; desc_user = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    rid = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst", 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("release_desc_ready", desc_ready, 1'b1);

    run_desc(32'h0000_1000, 0, 5'h03, -1, 1'b0, "single");
    chk("single_arlen", ar_len_at(0), 8'd0);

    run_desc(32'h0000_0000, 39, 5'h11, -1, 1'b0, "forty");
    chk("forty_arlen0", ar_len_at(0), 8'd15);
    chk("forty_arlen1", ar_len_at(1), 8'd15);
    chk("forty_arlen2", ar_len_at(2), 8'd7);
    chk("forty_addr1", ar_addr_at(1), 32'h100);
    chk("forty_addr2", ar_addr_at(2), 32'h200);

    run_desc(32'h0000_0FC0, 7, 5'h0A, -1, 1'b0, "split");
    chk("split_addr0", ar_addr_at(0), 32'h0FC0);
    chk("split_arlen0", ar_len_at(0), 8'd3);
    chk("split_addr1", ar_addr_at(1), 32'h1000);
    chk("split_arlen1", ar_len_at(1), 8'd3);

    tready_pct = 30; arready_pct = 50; rvalid_pct = 70;
    ra = $urandom & 32'h0000_3FF0;
    run_desc(ra, 63, 5'(($urandom)), -1, 1'b0, "rand64");
    ra = $urandom & 32'h0000_3FF0;
    run_desc(ra, $urandom_range(0, 63), 5'(($urandom)), -1, 1'b0, "randlen");
    tready_pct = 100; arready_pct = 100; rvalid_pct = 100;

    run_desc(32'h0000_2000, 7, 5'h15, 2, 1'b1, "slverr");
    run_desc(32'h0000_2100, 7, 5'h16, -1, 1'b0, "clean");

    send_desc(32'h0000_3000, 31, 5'h1F, "midrst");
    for (int k = 0; k < 2000 && got.size() < 6; k++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst", 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_desc(32'h0000_3400, 15, 5'h07, -1, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/artec_axi_to_axis_rd.md
# artec_axi_to_axis_rd

Read-side counterpart of the DMA write path: accepts one read descriptor at a time, fetches the memory region over a 128-bit AXI4 read master, and replays it as a 64-bit AXI-Stream with `tlast` on the final beat. Sits between the descriptor/header control logic and a downstream AXIS consumer on the DMA core clock. Completion and response-error status are reported per descriptor.

## Interface
- `AW`, 32: AXI address width
- `DW`, 128: AXI data width; fixed 2×`SDW`
- `SDW`, 64: AXIS data width
- `UW`, 5: AXIS `tuser` width (channel tag)
- `IDW`, 4: AXI ID width
- `MAXB`, 16: max beats per AXI burst
- `clk` in 1: core clock
- `rst` in 1: asynchronous, active-high reset
- `desc_valid` in 1 / `desc_ready` out 1: descriptor handshake
- `desc_addr` in AW: start byte address, 16-byte aligned (low 4 bits ignored)
- `desc_len` in 16: number of 128-bit beats minus 1
- `desc_user` in UW: tag driven on `tuser` for the whole transfer
- `arvalid` out 1, `arready` in 1, `araddr` out AW, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arid` out IDW
- `rvalid` in 1, `rready` out 1, `rdata` in DW, `rresp` in 2, `rlast` in 1, `rid` in IDW
- `tvalid` out 1, `tready` in 1, `tdata` out SDW, `tkeep` out SDW/8, `tlast` out 1, `tuser` out UW
- `done` out 1: one-cycle pulse at descriptor completion
- `err` out 1: valid with `done`; 1 if any `rresp` ≠ OKAY in that descriptor

## Operation
- FSM `IDLE → ADDR → DRAIN → IDLE`. `desc_ready` = 1 only in `IDLE`; accept latches addr, remaining beats = `desc_len`+1, user; clears error accumulator.
- `ADDR`: issue bursts. Burst beats = min(remaining, `MAXB`, (4096 − addr[11:0])/16); never crosses 4 KB. `arlen` = beats−1, `arsize` = 3'b100, `arburst` = INCR, `arid` = 0. On AR handshake: addr += beats×16, remaining −= beats. Max 2 bursts outstanding (counter incremented on AR, decremented on R with `rlast`); `arvalid` held low at limit. When remaining reaches 0 → `DRAIN`.
- `DRAIN`: wait for outstanding = 0 and output gearbox empty → `done` pulse, `IDLE`.
- Gearbox: each accepted R beat emits `rdata[63:0]` then `rdata[127:64]`. `tkeep` all ones. `tlast` on the upper half of the descriptor's final R beat only (burst `rlast` not forwarded). `tuser` = latched tag.
- `rresp` ≠ 2'b00: data still forwarded, error accumulator set; reported on `err` with `done`.
- `rid` ignored (single ID, in-order).

## Timing
- Reset values: `desc_ready`=0 during reset, 1 first cycle after release; `arvalid`, `rready`, `tvalid`, `tlast`, `done`, `err`=0; `araddr`, `arlen`, `tdata`, `tuser`=0.
- Descriptor accepted cycle N → `arvalid` at N+1.
- AR fields stable while `arvalid && !arready`; next AR no earlier than cycle after handshake.
- R beat accepted cycle M → low half `tvalid` at M+1, high half at M+2 if `tready` held.
- `rready` = gearbox empty, or holding only high half and `tready` (back-to-back: 1 AXIS beat/cycle sustained).
- `tvalid`/`tdata`/`tlast` stable until `tready`.
- `done` asserts the cycle after the `tlast` handshake; `desc_ready` returns that same cycle.
- Reset mid-transfer: all state cleared immediately; outstanding AXI transactions abandoned (interconnect reset together with block).

## Structure
- `artec_dma_pkg`: `AXI_BURST_INCR`, `AXI_SIZE_16B`, `AXI_RESP_OKAY`, 4 KB constant, read FSM state enum.
- Sub-module `artec_r2axis_gearbox`: 128→64 downsizer with R/AXIS handshakes, tlast and tuser insertion.
- Top holds FSM, burst splitter and outstanding counter.

## Test plan
- addr 0x1000, len 0 → one AR (arlen 0), two AXIS beats, `tlast` on second, `done`=1, `err`=0.
- addr 0x0000, len 39 (40 beats) → ARs arlen 15, 15, 7 at 0x000, 0x100, 0x200; 80 AXIS beats, data order checked.
- addr 0x0FC0, len 7 → ARs arlen 3 at 0x0FC0 and arlen 3 at 0x1000 (4 KB split).
- Random `tready` 30% and `arready` delays, 64 beats → no lost/duplicated data, ≤2 outstanding bursts.
- `rresp`=SLVERR on beat 3 of 8 → all 16 AXIS beats delivered, `done` with `err`=1; next clean descriptor gives `err`=0.
- `rst` asserted mid-burst → all outputs at reset values next cycle; new descriptor completes correctly.
